// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (configurable data width,
// optional odd/even parity, one or two stop bits) with a one-deep holding
// buffer so frames can stream back-to-back without an idle gap.
module uart_tx_param #(
  parameter int CLOCKS_PER_BIT = 87,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS      = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 has_data,
  input  logic [DATA_BITS-1:0] data_to_send,
  output logic                 ready,
  output logic                 sending_bit,
  output logic                 is_transmitting,
  output logic                 transmission_done
);

  // Elaboration-time parameter sanity: a bad configuration must not build.
  if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
    $fatal(1, "uart_tx_param: CLOCKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $fatal(1, "uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $fatal(1, "uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam logic             HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q,    state_d;
  logic [CNT_W-1:0]       bit_cnt_q,  bit_cnt_d;
  logic [IDX_W-1:0]       data_idx_q, data_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   shift_q,    shift_d;
  logic [DATA_BITS-1:0]   buf_q,      buf_d;
  logic                   buf_full_q, buf_full_d;
  logic                   par_q,      par_d;
  logic                   line_q,     line_d;
  logic                   done_q,     done_d;

  logic                   accept;
  logic                   tick;
  logic                   do_load;
  logic                   direct;
  logic [DATA_BITS-1:0]   load_word;

  // ready comes straight from the buffer flag, so there is no path from has_data.
  assign ready             = ~buf_full_q;
  assign accept            = has_data & ~buf_full_q;
  assign tick              = (bit_cnt_q == BIT_LAST);
  assign sending_bit       = line_q;
  assign is_transmitting   = (state_q != S_IDLE);
  assign transmission_done = done_q;

  // Next-state, line level and buffer bookkeeping.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_idx_d = data_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    par_d      = par_q;
    line_d     = line_q;
    done_d     = 1'b0;
    do_load    = 1'b0;
    direct     = 1'b0;
    load_word  = buf_q;

    // Bit-time counter wraps to 0 on every bit boundary.
    if (state_q != S_IDLE)
      bit_cnt_d = tick ? '0 : bit_cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        line_d = 1'b1;
        if (buf_full_q) begin
          do_load    = 1'b1;
          load_word  = buf_q;
          buf_full_d = 1'b0;
          state_d    = S_START;
          line_d     = 1'b0;
        end else if (accept) begin
          do_load   = 1'b1;
          load_word = data_to_send;
          direct    = 1'b1;
          state_d   = S_START;
          line_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d    = S_DATA;
          data_idx_d = '0;
          line_d     = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (data_idx_q == DATA_LAST) begin
            if (HAS_PAR) begin
              state_d = S_PARITY;
              line_d  = par_q;
            end else begin
              state_d    = S_STOP;
              stop_idx_d = 1'b0;
              line_d     = 1'b1;
            end
          end else begin
            data_idx_d = data_idx_q + IDX_W'(1);
            shift_d    = shift_q >> 1;
            line_d     = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          line_d     = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_idx_q == STOP_LAST) begin
            // Frame ends here; chain straight into the next start bit if possible.
            done_d = 1'b1;
            if (buf_full_q) begin
              do_load    = 1'b1;
              load_word  = buf_q;
              buf_full_d = 1'b0;
              state_d    = S_START;
              line_d     = 1'b0;
            end else if (accept) begin
              do_load   = 1'b1;
              load_word = data_to_send;
              direct    = 1'b1;
              state_d   = S_START;
              line_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              line_d  = 1'b1;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
            line_d     = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        line_d  = 1'b1;
      end
    endcase

    // Words accepted mid-frame park in the holding buffer.
    if (accept && (state_q != S_IDLE) && !direct) begin
      buf_d      = data_to_send;
      buf_full_d = 1'b1;
    end

    // Parity is fixed at load time from the latched payload.
    if (do_load) begin
      shift_d = load_word;
      par_d   = (^load_word) ^ PAR_ODD;
    end
  end

  // State and datapath registers; async reset drops the line to idle and flushes the buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      data_idx_q <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      par_q      <= 1'b0;
      line_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_idx_q <= data_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      par_q      <= par_d;
      line_q     <= line_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: several configurations run side by side, each
// checked every cycle against a frame-position reference model, plus
// literal frame patterns for directed words and a mid-frame reset.
module tb_uart_tx_param;

  localparam int NC = 5;
  localparam int C_CPB [NC] = '{4, 4, 4, 4, 5};
  localparam int C_DB  [NC] = '{8, 8, 8, 7, 9};
  localparam int C_PAR [NC] = '{0, 2, 1, 0, 1};
  localparam int C_SB  [NC] = '{1, 1, 1, 2, 2};
  // Directed words and their expected line bits (bit k = k-th bit on the wire).
  localparam int C_W1  [NC] = '{'hA5,  'h07,  'h07,  'h55,  'h103};
  localparam int C_E1  [NC] = '{'h34A, 'h60E, 'h40E, 'h3AA, 'h1A06};
  localparam int C_W2  [NC] = '{'h3C,  'h03,  'h03,  'h2A,  'h1FF};
  localparam int C_E2  [NC] = '{'h278, 'h406, 'h606, 'h354, 'h1BFE};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit fin [NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int CPB   = C_CPB[g];
    localparam int DB    = C_DB[g];
    localparam int PAR   = C_PAR[g];
    localparam int SB    = C_SB[g];
    localparam int NB    = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FRAME = CPB * NB;

    logic          rst_n    = 1'b0;
    logic          has_data = 1'b0;
    logic [DB-1:0] data     = '0;
    logic          ready, line, busy, done;

    uart_tx_param #(
      .CLOCKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)
    ) u_dut (
      .clock(clock), .reset_n(rst_n), .has_data(has_data), .data_to_send(data),
      .ready(ready), .sending_bit(line), .is_transmitting(busy),
      .transmission_done(done)
    );

    // Reference: a frame is just a bit list; pos counts cycles into it.
    bit            m_busy = 1'b0;
    bit            m_pend = 1'b0;
    bit            m_done = 1'b0;
    int            m_pos  = 0;
    logic [DB-1:0] m_cur  = '0;
    logic [DB-1:0] m_buf  = '0;

    function automatic logic bit_at(int k, logic [DB-1:0] w);
      if (k == 0) return 1'b0;
      if (k <= DB) return w[k-1];
      if (PAR != 0 && k == DB + 1) return (^w) ^ (PAR == 1);
      return 1'b1;
    endfunction

    initial forever begin
      bit acc;
      bit took;
      @(posedge clock or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_pend = 0; m_done = 0; m_pos = 0;
      end else begin
        acc    = has_data && !m_pend;
        took   = 0;
        m_done = 0;
        if (m_busy) begin
          m_pos++;
          if (m_pos == FRAME) begin
            m_done = 1;
            m_pos  = 0;
            if (m_pend) begin
              m_cur  = m_buf;
              m_pend = 0;
            end else if (acc) begin
              m_cur = data;
              took  = 1;
            end else begin
              m_busy = 0;
            end
          end
        end else if (acc) begin
          m_busy = 1;
          m_pos  = 0;
          m_cur  = data;
          took   = 1;
        end
        if (acc && !took) begin
          m_pend = 1;
          m_buf  = data;
        end
      end
    end

    // Per-cycle comparison against the reference, sampled mid-cycle.
    initial forever begin
      @(negedge clock);
      if (!fin[g]) begin
        chk($sformatf("c%0d_line", g), line, m_busy ? bit_at(m_pos / CPB, m_cur) : 1'b1);
        chk($sformatf("c%0d_ready", g), ready, !m_pend);
        chk($sformatf("c%0d_busy", g), busy, m_busy);
        chk($sformatf("c%0d_done", g), done, m_done);
      end
    end

    // Stimulus: reset, directed words, streaming, random traffic, mid-frame reset.
    initial begin
      logic [31:0] r;
      int          w;
      int          e;
      int          cap;
      int          lows;
      bit          found;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk($sformatf("c%0d_rst_line", g), line, 1'b1);
      chk($sformatf("c%0d_rst_ready", g), ready, 1'b1);
      chk($sformatf("c%0d_rst_busy", g), busy, 1'b0);
      chk($sformatf("c%0d_rst_done", g), done, 1'b0);
      @(posedge clock); #1 rst_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // Directed frames; data_to_send keeps changing after acceptance.
      for (int d = 0; d < 2; d++) begin
        w = (d == 0) ? C_W1[g] : C_W2[g];
        e = (d == 0) ? C_E1[g] : C_E2[g];
        has_data = 1'b1;
        data     = w[DB-1:0];
        @(posedge clock);
        cap = 0;
        for (int n = 0; n < FRAME; n++) begin
          @(negedge clock);
          has_data = 1'b0;
          r        = $urandom;
          data     = r[DB-1:0];
          if (n % CPB == CPB / 2) cap[n / CPB] = line;
        end
        chk($sformatf("c%0d_frame%0d", g, d), cap, e);
        repeat (4) @(posedge clock);
        #1;
      end

      // Continuous offer: buffer fills, later words wait, frames abut.
      has_data = 1'b1;
      repeat (3 * FRAME) begin
        r    = $urandom;
        data = r[DB-1:0];
        @(posedge clock); #1;
      end
      has_data = 1'b0;
      repeat (2 * FRAME + 4) @(posedge clock);
      #1;

      // Random sparse traffic.
      repeat (12 * FRAME) begin
        has_data = ($urandom % 4 == 0);
        r        = $urandom;
        data     = r[DB-1:0];
        @(posedge clock); #1;
      end
      has_data = 1'b0;
      repeat (2 * FRAME + 4) @(posedge clock);
      #1;

      // Reset during data bit 3 with a word buffered.
      has_data = 1'b1;
      found    = 1'b0;
      for (int i = 0; i < 4 * FRAME && !found; i++) begin
        @(negedge clock);
        r    = $urandom;
        data = r[DB-1:0];
        if (m_busy && m_pend && (m_pos / CPB == 4)) found = 1'b1;
      end
      chk($sformatf("c%0d_rst_window", g), found, 1'b1);
      #1 rst_n = 1'b0;
      has_data = 1'b0;
      #1;
      chk($sformatf("c%0d_arst_line", g), line, 1'b1);
      chk($sformatf("c%0d_arst_ready", g), ready, 1'b1);
      chk($sformatf("c%0d_arst_busy", g), busy, 1'b0);
      chk($sformatf("c%0d_arst_done", g), done, 1'b0);
      repeat (3) @(posedge clock);
      #1 rst_n = 1'b1;
      lows = 0;
      repeat (3 * FRAME) begin
        @(negedge clock);
        if (line == 1'b0 || busy) lows++;
      end
      chk($sformatf("c%0d_no_resume", g), lows, 0);
      fin[g] = 1'b1;
    end
  end

  initial begin
    bit all_fin;
    all_fin = 1'b0;
    for (int i = 0; i < 60000 && !all_fin; i++) begin
      @(posedge clock);
      all_fin = 1'b1;
      for (int k = 0; k < NC; k++) if (!fin[k]) all_fin = 1'b0;
    end
    chk("timeout", all_fin, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter for the FPGA sensor link, successor to the fixed 8N1 transmitter. It serialises words of configurable width with optional odd/even parity and one or two stop bits. A one-deep holding buffer behind a valid/ready handshake lets frames go out back-to-back with no idle gap. It sits between the sensor-response formatter and the FPGA TX pin.

## Interface
- `CLOCKS_PER_BIT`, 87: clock cycles per bit, equal to f_clock / baud; legal range ≥ 2.
- `DATA_BITS`, 8: payload width; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `has_data`  in  1  valid; a word is offered on `data_to_send`.
- `data_to_send`  in  DATA_BITS  word to transmit; sampled only on acceptance.
- `ready`  out  1  the block can accept a word this cycle.
- `sending_bit`  out  1  serial line, registered; idle level is 1.
- `is_transmitting`  out  1  a frame is in progress.
- `transmission_done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- **Acceptance:** a word is accepted on a rising edge where `has_data && ready`.
- **`ready`:** equals NOT buffer_full, decoded from a register with no combinational path from `has_data`.
- **States:** IDLE → START → DATA → PARITY (only when PARITY≠0) → STOP → IDLE or START.
- **Bit timing:** every state except IDLE holds its line level for exactly CLOCKS_PER_BIT cycles.
- **Bit counter:** width is $clog2(CLOCKS_PER_BIT). It resets to 0 on every bit boundary.
- **Data and stop counters:** the data-bit index counts 0..DATA_BITS-1 and the stop-bit index counts 0..STOP_BITS-1.
- **IDLE with buffer empty:** an accepted word loads the shift register directly, and the state goes to START.
- **IDLE with buffer full:** this occurs only after a mid-frame accept. The buffer moves to the shifter and the state goes to START.
- **Accept while busy:** a word accepted when the state is not IDLE goes into the holding buffer, and `ready` falls.
- **Bit order:** data goes out LSB first from the latched shifter. Input changes after acceptance have no effect.
- **Parity bit:** XOR of the latched payload. It is inverted for odd parity, so the total count of ones in data plus parity is odd. Even parity uses the XOR unchanged.
- **End of the final stop bit:**
  - `transmission_done` pulses.
  - If the buffer is full, the buffer loads the shifter, the state goes to START with no idle cycle, and `ready` rises.
  - Otherwise, if `has_data && ready`, the word goes straight into the shifter and the state goes to START.
  - Otherwise the state goes to IDLE.
- **Buffer full:** `has_data` is ignored and the pending word is not overwritten.
- **Illegal parameter values:** out-of-range DATA_BITS, PARITY or STOP_BITS halt elaboration through a generate-time check.

## Timing
- **Reset values:** `sending_bit`=1, `ready`=1, `is_transmitting`=0, `transmission_done`=0. State is IDLE, all counters are 0 and the buffer is empty.
- **Reset mid-frame:** takes effect immediately and asynchronously. The line returns to 1 and any buffered word is discarded.
- **Start latency:** `sending_bit` goes to 0 at the acceptance edge, registered, so it is visible the cycle after acceptance.
- **`is_transmitting`:** rises at the same edge.
- **Frame length:** CLOCKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- **Frame end:** at the frame-end edge, `transmission_done` = 1 for exactly one cycle. `is_transmitting` falls at the same edge unless a back-to-back frame starts.
- **Back-to-back frames:** the next start bit begins at the same edge as the previous frame ends. Each frame produces its own `transmission_done` pulse.
- **Throughput:** continuous streaming runs at one word per frame time with no gap.

## Test plan
- **8N1 single word:** CLOCKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1. Send 0xA5. The line reads 0, 1,0,1,0,0,1,0,1, 1, with each bit 4 cycles long. `transmission_done` pulses once, 40 cycles after acceptance, and `is_transmitting` is high for exactly those 40 cycles.
- **Even parity:** PARITY=2. Send 0x07; the parity bit is 1. Send 0x03; the parity bit is 0. PARITY=1 with 0x07 gives parity bit 0.
- **7 data bits, 2 stop bits:** send 0x55. The line reads 0, 1,0,1,0,1,0,1, 1, 1. The frame is 40 cycles at CLOCKS_PER_BIT=4.
- **Back-to-back with buffer:**
  - Hold `has_data` high with 0x11 then 0x22.
  - `ready` drops after the second accept and rises at the end of the first frame.
  - The second start bit follows the first stop bit with no idle cycle, and there are two `transmission_done` pulses 40 cycles apart.
  - A third word offered while the buffer is full is not accepted.
- **Reset mid-data-bit:** assert `reset_n`=0 during data bit 3 with a word buffered. All outputs return to their reset values asynchronously. After release, no frame resumes and the buffered word is never sent.
- **Input stability:** change `data_to_send` every cycle after acceptance. The transmitted bits match the word sampled at the acceptance edge.
